// File: rtl/hwpe_stream_source_credit.sv
// Multi-port TCDM load streamer: linear address generator, credit-bounded request issue and
// per-port response FIFOs merged into a single output stream.
module hwpe_stream_source_credit #(
    parameter int unsigned NB_PORTS   = 2,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clear_i,
    input  logic                     ctrl_req_start_i,
    input  logic [31:0]              ctrl_base_addr_i,
    input  logic [CNT_WIDTH-1:0]     ctrl_trans_size_i,
    input  logic [31:0]              ctrl_stride_i,
    output logic                     flags_ready_start_o,
    output logic                     flags_in_progress_o,
    output logic                     flags_done_o,
    output logic [NB_PORTS-1:0]      tcdm_req_o,
    input  logic [NB_PORTS-1:0]      tcdm_gnt_i,
    output logic [NB_PORTS*32-1:0]   tcdm_add_o,
    output logic [NB_PORTS-1:0]      tcdm_wen_o,
    output logic [NB_PORTS*4-1:0]    tcdm_be_o,
    output logic [NB_PORTS*32-1:0]   tcdm_data_o,
    input  logic [NB_PORTS*32-1:0]   tcdm_r_data_i,
    input  logic [NB_PORTS-1:0]      tcdm_r_valid_i,
    output logic                     stream_valid_o,
    input  logic                     stream_ready_i,
    output logic [NB_PORTS*32-1:0]   stream_data_o,
    output logic [NB_PORTS*4-1:0]    stream_strb_o
);

    localparam int unsigned CredW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWorking, StDrain} state_e;

    state_e               state_q, state_d;
    logic [31:0]          addr_q;
    logic [31:0]          stride_q;
    logic [CNT_WIDTH-1:0] size_q;
    logic [CNT_WIDTH-1:0] issued_q;
    logic [CNT_WIDTH-1:0] popped_q;
    logic [CredW-1:0]     credits_q;
    logic [NB_PORTS-1:0]  fence_q;
    logic                 done_q;
    logic                 drop_q;

    logic                 soft_rst;
    logic                 start;
    logic                 start_zero;
    logic                 can_issue;
    logic                 beat_done;
    logic                 pop;
    logic                 last_pop;
    logic [NB_PORTS-1:0]  req;
    logic [NB_PORTS-1:0]  gnt_eff;
    logic [NB_PORTS-1:0]  push;
    logic [NB_PORTS-1:0]  fifo_empty;

    assign soft_rst   = rst_i | clear_i;
    assign start      = (state_q == StIdle) & ctrl_req_start_i;
    assign start_zero = start & (ctrl_trans_size_i == '0);

    // Credits cap beats granted but not yet popped, so the FIFOs can never overflow.
    assign can_issue = (state_q == StWorking) & (issued_q < size_q) & (credits_q != '0);
    assign req       = can_issue ? ~fence_q : '0;
    assign gnt_eff   = tcdm_gnt_i & req;
    assign beat_done = can_issue & (&(fence_q | gnt_eff));

    assign stream_valid_o = ~|fifo_empty;
    assign pop            = stream_valid_o & stream_ready_i;
    assign last_pop       = pop & (state_q == StDrain) & (popped_q == size_q - CNT_WIDTH'(1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (start && !start_zero) state_d = StWorking;
            StWorking: if (issued_q == size_q) state_d = StDrain;
            StDrain:   if (last_pop) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (soft_rst) begin
            state_q   <= StIdle;
            addr_q    <= '0;
            stride_q  <= '0;
            size_q    <= '0;
            issued_q  <= '0;
            popped_q  <= '0;
            credits_q <= CredW'(FIFO_DEPTH);
            fence_q   <= '0;
            done_q    <= 1'b0;
            drop_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            done_q  <= start_zero | last_pop;
            drop_q  <= 1'b0;
            if (start) begin
                addr_q   <= ctrl_base_addr_i;
                stride_q <= ctrl_stride_i;
                size_q   <= ctrl_trans_size_i;
                issued_q <= '0;
                popped_q <= '0;
            end else begin
                if (beat_done) begin
                    addr_q   <= addr_q + stride_q;
                    issued_q <= issued_q + CNT_WIDTH'(1);
                end
                if (pop) popped_q <= popped_q + CNT_WIDTH'(1);
            end
            fence_q <= beat_done ? '0 : (fence_q | gnt_eff);
            case ({pop, beat_done})
                2'b10:   credits_q <= credits_q + CredW'(1);
                2'b01:   credits_q <= credits_q - CredW'(1);
                default: credits_q <= credits_q;
            endcase
        end
    end

    for (genvar i = 0; i < NB_PORTS; i++) begin : g_port
        logic [31:0]      mem [FIFO_DEPTH];
        logic [PtrW-1:0]  wptr_q;
        logic [PtrW-1:0]  rptr_q;
        logic [CredW-1:0] cnt_q;
        logic             full;

        // Responses to requests granted before a reset/clear are discarded.
        assign push[i]       = tcdm_r_valid_i[i] & ~drop_q;
        assign fifo_empty[i] = (cnt_q == '0);
        assign full          = (cnt_q == CredW'(FIFO_DEPTH));

        assign tcdm_add_o[32*i +: 32]    = addr_q + 32'(4 * i);
        assign stream_data_o[32*i +: 32] = mem[rptr_q];

        always_ff @(posedge clk_i) begin
            if (push[i]) mem[wptr_q] <= tcdm_r_data_i[32*i +: 32];
        end

        always_ff @(posedge clk_i) begin
            if (soft_rst) begin
                wptr_q <= '0;
                rptr_q <= '0;
                cnt_q  <= '0;
            end else begin
                if (push[i]) begin
                    wptr_q <= (wptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wptr_q + PtrW'(1);
                end
                if (pop) begin
                    rptr_q <= (rptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rptr_q + PtrW'(1);
                end
                case ({push[i], pop})
                    2'b10:   cnt_q <= cnt_q + CredW'(1);
                    2'b01:   cnt_q <= cnt_q - CredW'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        assert property (@(posedge clk_i) disable iff (soft_rst) push[i] |-> !full)
            else $error("push into full response FIFO on port %0d", i);
    end

    assign tcdm_req_o          = req;
    assign tcdm_wen_o          = '1;
    assign tcdm_be_o           = '0;
    assign tcdm_data_o         = '0;
    assign stream_strb_o       = {(NB_PORTS * 4){stream_valid_o}};
    assign flags_ready_start_o = (state_q == StIdle);
    assign flags_in_progress_o = (state_q == StWorking) | (state_q == StDrain);
    assign flags_done_o        = done_q;

endmodule

// File: tb/tb_hwpe_stream_source_credit.sv
// Bench for hwpe_stream_source_credit: directed transfers checked every cycle against a
// beat-level model (grant/response/pop counts), plus literal expectations per scenario.
module tb_hwpe_stream_source_credit;

    localparam int unsigned NP    = 2;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              clear = 1'b0;
    logic              start = 1'b0;
    logic [31:0]       base_in = '0;
    logic [31:0]       stride_in = '0;
    logic [CW-1:0]     size_in = '0;
    logic              ready_start, in_prog, done;
    logic [NP-1:0]     req, wen;
    logic [NP-1:0]     gnt = '0;
    logic [NP-1:0]     r_valid = '0;
    logic [NP*32-1:0]  r_data = '0;
    logic [NP*32-1:0]  add, wdata, s_data;
    logic [NP*4-1:0]   be, s_strb;
    logic              s_valid;
    logic              s_ready = 1'b1;
    logic [NP-1:0]     gnt_mask = '1;

    int checks = 0;
    int errors = 0;

    hwpe_stream_source_credit #(
        .NB_PORTS   (NP),
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .clear_i             (clear),
        .ctrl_req_start_i    (start),
        .ctrl_base_addr_i    (base_in),
        .ctrl_trans_size_i   (size_in),
        .ctrl_stride_i       (stride_in),
        .flags_ready_start_o (ready_start),
        .flags_in_progress_o (in_prog),
        .flags_done_o        (done),
        .tcdm_req_o          (req),
        .tcdm_gnt_i          (gnt),
        .tcdm_add_o          (add),
        .tcdm_wen_o          (wen),
        .tcdm_be_o           (be),
        .tcdm_data_o         (wdata),
        .tcdm_r_data_i       (r_data),
        .tcdm_r_valid_i      (r_valid),
        .stream_valid_o      (s_valid),
        .stream_ready_i      (s_ready),
        .stream_data_o       (s_data),
        .stream_strb_o       (s_strb)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // TCDM memory: grants what the mask allows, answers exactly one cycle later.
    logic [NP-1:0]    pend_valid = '0;
    logic [NP*32-1:0] pend_data = '0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            r_valid = pend_valid;
            r_data  = pend_data;
            gnt     = req & gnt_mask;
            pend_valid = gnt;
            for (int i = 0; i < NP; i++) pend_data[32*i +: 32] = memf(add[32*i +: 32]);
        end
    end

    // Beat-level model: a beat is done when every port has been granted it; a beat is
    // poppable once every port has returned it; credits = DEPTH - (done beats - popped).
    bit               m_idle = 1'b1;
    bit               m_done_due = 1'b0;
    bit               m_drop = 1'b1;
    logic [31:0]      m_base = '0;
    logic [31:0]      m_stride = '0;
    int unsigned      m_size = 0;
    int unsigned      m_pops = 0;
    int unsigned      m_grants [NP];
    int unsigned      m_resp [NP];
    logic [NP-1:0]    prev_req = '0;
    logic [NP-1:0]    prev_gnt = '0;
    bit               prev_hold = 1'b0;
    logic [NP*32-1:0] prev_data = '0;

    int unsigned      mn, avail;
    logic [NP-1:0]    exp_req;
    bit               exp_valid, was_idle, next_done;
    logic [31:0]      ea;
    logic [NP*32-1:0] eb;

    always @(negedge clk) begin
        if (rst || clear) begin
            m_idle = 1'b1;
            m_pops = 0;
            m_done_due = 1'b0;
            m_drop = 1'b1;
            for (int i = 0; i < NP; i++) begin
                m_grants[i] = 0;
                m_resp[i] = 0;
            end
            prev_req = '0;
            prev_gnt = '0;
            prev_hold = 1'b0;
        end else begin
            mn = m_grants[0];
            avail = m_resp[0];
            for (int i = 1; i < NP; i++) begin
                if (m_grants[i] < mn) mn = m_grants[i];
                if (m_resp[i] < avail) avail = m_resp[i];
            end
            exp_valid = !m_idle && (avail > m_pops);
            for (int i = 0; i < NP; i++) begin
                exp_req[i] = !m_idle && (m_grants[i] == mn) && (mn < m_size)
                             && ((mn - m_pops) < DEPTH);
            end
            chk("ready_start", ready_start, m_idle);
            chk("in_progress", in_prog, !m_idle);
            chk("done", done, m_done_due);
            chk("req", req, exp_req);
            chk("stream_valid", s_valid, exp_valid);
            for (int i = 0; i < NP; i++) begin
                if (prev_req[i] && !prev_gnt[i]) chk("req_held", req[i], 1'b1);
                if (exp_req[i]) begin
                    ea = m_base + m_grants[i] * m_stride + 4 * i;
                    chk("addr", add[32*i +: 32], ea);
                end
            end
            if (exp_valid) begin
                for (int i = 0; i < NP; i++) begin
                    ea = m_base + m_pops * m_stride + 4 * i;
                    eb[32*i +: 32] = memf(ea);
                end
                chk("stream_data", s_data, eb);
                chk("stream_strb", s_strb, {(NP * 4){1'b1}});
            end
            if (prev_hold) chk("hold_data", s_data, prev_data);

            next_done = 1'b0;
            was_idle = m_idle;
            for (int i = 0; i < NP; i++) begin
                if (req[i] && gnt[i]) m_grants[i]++;
                if (!m_drop && r_valid[i]) m_resp[i]++;
            end
            prev_hold = exp_valid && !s_ready;
            prev_data = s_data;
            if (exp_valid && s_ready) begin
                m_pops++;
                if (m_pops == m_size) begin
                    m_idle = 1'b1;
                    next_done = 1'b1;
                end
            end
            if (start && was_idle) begin
                m_base = base_in;
                m_stride = stride_in;
                m_size = size_in;
                m_pops = 0;
                for (int i = 0; i < NP; i++) begin
                    m_grants[i] = 0;
                    m_resp[i] = 0;
                end
                if (size_in == '0) next_done = 1'b1;
                else m_idle = 1'b0;
            end
            prev_req = req;
            prev_gnt = gnt;
            m_drop = 1'b0;
            m_done_due = next_done;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Returns in the first cycle after the start was accepted.
    task automatic go(input logic [31:0] b, input logic [31:0] s, input logic [CW-1:0] n);
        base_in = b;
        stride_in = s;
        size_in = n;
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick(1);
            n++;
        end
        chk({name, "_done_seen"}, done, 1'b1);
        tick(2);
    endtask

    logic [NP-1:0] gpat [5] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b11};
    logic          rpat [3] = '{1'b1, 1'b0, 1'b0};
    int            beats;

    initial begin
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_ready_start", ready_start, 1'b1);
        chk("rst_in_progress", in_prog, 1'b0);
        chk("rst_req", req, 2'b00);
        chk("rst_valid", s_valid, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("const_wen", wen, 2'b11);
        chk("const_be", be, 8'h00);
        chk("const_wdata", wdata, 64'h0);

        // Basic: full grants, ready high.
        go(32'h100, 32'd8, 16'd4);
        chk("t1_req_beat0", req, 2'b11);
        chk("t1_add_beat0", add, 64'h0000_0104_0000_0100);
        tick(1);
        chk("t1_add_beat1", add, 64'h0000_010C_0000_0108);
        tick(1);
        chk("t1_first_valid", s_valid, 1'b1);
        chk("t1_first_data", s_data, {memf(32'h104), memf(32'h100)});
        for (int k = 0; k < 3; k++) begin
            tick(1);
            chk("t1_no_gap", s_valid, 1'b1);
        end
        tick(1);
        chk("t1_done", done, 1'b1);
        chk("t1_idle", ready_start, 1'b1);
        tick(1);
        chk("t1_done_pulse", done, 1'b0);
        tick(2);

        // Staggered grants: port 0 first, port 1 two cycles later.
        gnt_mask = 2'b01;
        go(32'h200, 32'd16, 16'd2);
        chk("t2_req_c0", req, 2'b11);
        chk("t2_add_c0", add, 64'h0000_0204_0000_0200);
        gnt_mask = 2'b00;
        tick(1);
        chk("t2_req_c1", req, 2'b10);
        chk("t2_add_c1", add, 64'h0000_0204_0000_0200);
        gnt_mask = 2'b10;
        tick(1);
        chk("t2_req_c2", req, 2'b10);
        chk("t2_add_c2", add, 64'h0000_0204_0000_0200);
        gnt_mask = 2'b11;
        tick(1);
        chk("t2_req_beat1", req, 2'b11);
        chk("t2_add_beat1", add, 64'h0000_0214_0000_0210);
        wait_done("t2", 40);

        // Back-pressure: credits stop issue after DEPTH beats.
        s_ready = 1'b0;
        go(32'h300, 32'd8, 16'd8);
        beats = 0;
        for (int k = 0; k < 20; k++) begin
            if (gnt == 2'b11) beats++;
            tick(1);
        end
        chk("t3_beats_issued", beats, DEPTH);
        chk("t3_req_stalled", req, 2'b00);
        chk("t3_valid_held", s_valid, 1'b1);
        chk("t3_head_data", s_data, {memf(32'h304), memf(32'h300)});
        s_ready = 1'b1;
        wait_done("t3", 60);

        // Zero-length transfer.
        go(32'h400, 32'd4, 16'd0);
        chk("t4_done", done, 1'b1);
        chk("t4_idle", ready_start, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("t4_no_req", req, 2'b00);
            tick(1);
            chk("t4_done_low", done, 1'b0);
        end

        // Irregular grants and ready; a start while busy must be ignored.
        go(32'h700, 32'h20, 16'd6);
        for (int k = 0; k < 12; k++) begin
            gnt_mask = gpat[k % 5];
            s_ready = rpat[k % 3];
            start = (k == 5);
            base_in = 32'hDEAD_0000;
            tick(1);
        end
        start = 1'b0;
        gnt_mask = 2'b11;
        s_ready = 1'b1;
        wait_done("t7", 80);

        // Clear mid-transfer with responses in flight.
        go(32'h500, 32'd8, 16'd6);
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("t5_idle", ready_start, 1'b1);
        chk("t5_valid_low", s_valid, 1'b0);
        chk("t5_req_low", req, 2'b00);
        tick(1);
        chk("t5_late_rvalid_dropped", s_valid, 1'b0);
        tick(1);
        chk("t5_still_empty", s_valid, 1'b0);
        go(32'h600, 32'd12, 16'd3);
        chk("t5_restart_add", add, 64'h0000_0604_0000_0600);
        wait_done("t5", 40);

        // Address wrap-around.
        go(32'hFFFF_FFF8, 32'd8, 16'd3);
        chk("t6_add_beat0", add, 64'hFFFF_FFFC_FFFF_FFF8);
        tick(1);
        chk("t6_add_beat1", add, 64'h0000_0004_0000_0000);
        wait_done("t6", 40);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwpe_stream_source_credit.md
Name: hwpe_stream_source_credit

Overview:
Multi-port TCDM load streamer with an integrated linear address generator. Issues NB_PORTS-wide read beats, buffers responses in per-port FIFOs, and merges them into one output stream. Credit-based flow control bounds outstanding requests, so responses never overflow and r_valid is never back-pressured. It sits between the TCDM interconnect and an HWPE datapath and generalises the fixed-depth fence/merge source.

Parameters:
NB_PORTS, 2, number of 32-bit TCDM ports per beat (≥1)
FIFO_DEPTH, 4, per-port response FIFO depth in beats (≥2); also the credit limit
CNT_WIDTH, 16, width of the beat counters and trans_size

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
clear_i  in  1  synchronous soft clear, same effect as rst_i
ctrl_req_start_i  in  1  start request; honoured only in IDLE
ctrl_base_addr_i  in  32  byte address of beat 0, port 0
ctrl_trans_size_i  in  CNT_WIDTH  number of beats
ctrl_stride_i  in  32  byte distance between consecutive beats
flags_ready_start_o  out  1  high in IDLE
flags_in_progress_o  out  1  high in WORKING or DRAIN
flags_done_o  out  1  one-cycle pulse when the last beat is popped
tcdm_req_o  out  NB_PORTS  per-port request
tcdm_gnt_i  in  NB_PORTS  per-port grant
tcdm_add_o  out  NB_PORTS*32  per-port byte address
tcdm_wen_o  out  NB_PORTS  constant 1 (read)
tcdm_be_o  out  NB_PORTS*4  constant 0
tcdm_data_o  out  NB_PORTS*32  constant 0
tcdm_r_data_i  in  NB_PORTS*32  per-port read data
tcdm_r_valid_i  in  NB_PORTS  per-port response valid; arrives exactly 1 cycle after gnt
stream_valid_o  out  1  output beat valid
stream_ready_i  in  1  output beat ready
stream_data_o  out  NB_PORTS*32  port i occupies bits [32i+31:32i]
stream_strb_o  out  NB_PORTS*4  all ones when valid

Behaviour:
- Reset/clear values: state IDLE, all counters 0, credits=FIFO_DEPTH, FIFOs empty, fence mask 0. Outputs: tcdm_req_o=0, stream_valid_o=0, flags_done_o=0, flags_ready_start_o=1, flags_in_progress_o=0.
- Start: in IDLE with ctrl_req_start_i=1, latch base, stride and trans_size. If trans_size==0, pulse done the next cycle and stay IDLE. Otherwise go to WORKING. req_start outside IDLE is ignored.
- Address of beat k, port i: base + k*stride + 4*i, modulo 2^32. Address is held stable until the beat completes.
- Issue (WORKING): tcdm_req_o[i] = (issued<trans_size) & (credits>0) & ~fence[i].
  - fence[i] sets on gnt[i] for a partial beat.
  - A beat completes when (fence | gnt) is all ones. On completion: fence clears, issued++, credits--.
  - At most one beat is in granting at a time. Requests for a beat are never withdrawn once asserted.
- Response: r_valid[i] pushes r_data[i] into FIFO i. Overflow is impossible by the credit invariant. An assertion flags a push to a full FIFO.
- Output: stream_valid_o = all FIFOs non-empty, with data taken from the FIFO heads.
  - Handshake valid&ready pops all FIFOs together, popped++, credits++.
  - Valid and data stay stable while ready=0.
  - Credit increment and decrement in the same cycle leave credits unchanged.
- WORKING→DRAIN when issued==trans_size.
- DRAIN→IDLE on the pop with popped==trans_size-1; flags_done_o pulses the following cycle.
- Zero-wait throughput: 1 beat/cycle when gnt=all ones and ready=1 continuously.
- First stream_valid_o occurs 2 cycles after the first full grant (gnt cycle, r_valid cycle, FIFO registered).
- clear_i/rst_i mid-operation: return to reset values next cycle. r_valid arriving in the cycle immediately after clear/reset is dropped.

Test Plan:
- NB_PORTS=2, base=0x100, stride=8, trans_size=4, gnt=11, ready=1 → addresses 0x100/0x104, 0x108/0x10C …; 4 beats with data matching memory; done pulses once; no gaps after first valid.
- Staggered grants: port0 granted cycle 0, port1 cycle 2 → port0 req deasserted after its grant; beat counted once; address held 3 cycles.
- ready=0 for 20 cycles, FIFO_DEPTH=4 → exactly 4 beats issued, then tcdm_req_o=0; resuming ready drains in order with no loss or duplication.
- trans_size=0 → no tcdm_req_o ever; done pulse 1 cycle after start.
- clear_i mid-transfer with responses in flight → IDLE next cycle, stream_valid_o=0, late r_valid ignored; new start transfers correctly.
- Address wrap: base=0xFFFFFFF8, stride=8, NB_PORTS=2 → beat 1 addresses 0x00000000/0x00000004.
